// File: rtl/pc_irq_vec.sv
`default_nettype none
// ============================================================================
// Module   : pc_irq_vec
// Purpose  : Program counter with a vectored, maskable, prioritised interrupt
//            unit. The PC moves once per write-back strobe edge: it advances,
//            jumps, vectors to a channel handler, or returns from a handler.
//            Optional macro PC_NEST_EN replaces the single backup register
//            with a LIFO of NEST_DEPTH entries so that handlers can nest.
// Revision : 1.0 - initial release
// ============================================================================
module pc_irq_vec #(
  parameter int unsigned       ADDR_W     = 27,
  parameter int unsigned       NUM_INT    = 8,
  parameter logic [ADDR_W-1:0] PC_START   = 27'hC02422,
  parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(1),
  parameter int unsigned       NEST_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step,
  input  logic               jump,
  input  logic               offset,
  input  logic [ADDR_W-1:0]  jump_addr,
  input  logic               reti,
  input  logic [NUM_INT-1:0] int_req,
  input  logic               mask_wr,
  input  logic [NUM_INT-1:0] mask_data,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [7:0]         int_id,
  output logic               int_active,
  output logic [NUM_INT-1:0] pending
);

  // Reject configurations the channel id encoding or the stack cannot hold.
  if (NUM_INT < 1 || NUM_INT > 32 || NEST_DEPTH < 1) begin : g_bad_cfg
    $error("pc_irq_vec: NUM_INT must be 1..32 and NEST_DEPTH at least 1");
  end

  logic               step_prev_q;
  logic [NUM_INT-1:0] req_prev_q;
  logic [NUM_INT-1:0] pending_q, pending_d;
  logic [NUM_INT-1:0] mask_q, mask_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [7:0]         int_id_q, int_id_d;

  logic               step_edge;
  logic [NUM_INT-1:0] req_edge;
  logic [NUM_INT-1:0] eligible;
  logic [NUM_INT-1:0] take_clr;
  logic [7:0]         sel;
  logic [ADDR_W-1:0]  next_pc;
  logic [ADDR_W-1:0]  vec_pc;
  logic               below_rom;
  logic               take;
  logic               do_reti;

`ifdef PC_NEST_EN
  localparam int unsigned     SP_W    = $clog2(NEST_DEPTH + 1);
  localparam int unsigned     IDX_W   = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(NEST_DEPTH);

  logic [ADDR_W-1:0] stk_pc_q [2**IDX_W];
  logic [7:0]        stk_id_q [2**IDX_W];
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;
`else
  logic [ADDR_W-1:0] backup_q, backup_d;
  logic              int_en_q, int_en_d;
  logic              int_active_q, int_active_d;
`endif

  assign step_edge = step & ~step_prev_q;
  assign req_edge  = int_req & ~req_prev_q;
  assign eligible  = pending_q & mask_q;
  assign below_rom = (pc_q < PC_START);
  assign vec_pc    = VEC_BASE + ADDR_W'(sel);

`ifdef PC_NEST_EN
  assign push_idx = sp_q[IDX_W-1:0];
  assign pop_idx  = IDX_W'(sp_q - 1'b1);
  // A deeper take must outrank the running handler and find room on the stack.
  assign take     = step_edge & ~reti & (|eligible) & below_rom &
                    ((sp_q == '0) | ((sel < int_id_q) & (sp_q != SP_FULL)));
  assign do_reti  = step_edge & reti & (sp_q != '0);
`else
  assign take     = step_edge & ~reti & int_en_q & (|eligible) & below_rom;
  assign do_reti  = step_edge & reti & int_active_q;
`endif

  assign take_clr = take ? (NUM_INT'(1) << sel) : '0;

  // Lowest eligible index wins: scan downward so the last hit is the lowest.
  always_comb begin
    sel = '0;
    for (int i = NUM_INT - 1; i >= 0; i--) begin
      if (eligible[i]) sel = 8'(i);
    end
  end

  // Sequential address of the current instruction, all sums wrapping.
  always_comb begin
    if (jump && offset)  next_pc = pc_q + jump_addr;
    else if (jump)       next_pc = jump_addr;
    else                 next_pc = pc_q + ADDR_W'(1);
  end

  // Next-state selection: return, take, or plain advance, in that priority.
  always_comb begin
    pc_d      = pc_q;
    int_id_d  = int_id_q;
    pending_d = (pending_q & ~take_clr) | req_edge;   // a fresh edge beats the clear
    mask_d    = mask_wr ? mask_data : mask_q;
`ifdef PC_NEST_EN
    sp_d      = sp_q;
    if (do_reti) begin
      pc_d     = stk_pc_q[pop_idx];
      int_id_d = stk_id_q[pop_idx];
      sp_d     = sp_q - 1'b1;
    end else if (take) begin
      pc_d     = vec_pc;
      int_id_d = sel;
      sp_d     = sp_q + 1'b1;
    end else if (step_edge) begin
      pc_d     = next_pc;
    end
`else
    backup_d     = backup_q;
    int_en_d     = int_en_q;
    int_active_d = int_active_q;
    if (do_reti) begin
      pc_d         = backup_q;
      int_en_d     = 1'b1;
      int_active_d = 1'b0;
    end else if (take) begin
      backup_d     = next_pc;
      pc_d         = vec_pc;
      int_id_d     = sel;
      int_active_d = 1'b1;
      int_en_d     = 1'b0;
    end else if (step_edge) begin
      pc_d         = next_pc;
    end
`endif
  end

  // State register, updated on the falling edge with synchronous active-low reset.
  always_ff @(negedge clk) begin
    if (!reset) begin
      step_prev_q  <= 1'b0;
      req_prev_q   <= '0;
      pending_q    <= '0;
      mask_q       <= '1;
      pc_q         <= PC_START;
      int_id_q     <= '0;
`ifdef PC_NEST_EN
      sp_q         <= '0;
`else
      backup_q     <= '0;
      int_en_q     <= 1'b1;
      int_active_q <= 1'b0;
`endif
    end else begin
      step_prev_q  <= step;
      req_prev_q   <= int_req;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      pc_q         <= pc_d;
      int_id_q     <= int_id_d;
`ifdef PC_NEST_EN
      sp_q         <= sp_d;
`else
      backup_q     <= backup_d;
      int_en_q     <= int_en_d;
      int_active_q <= int_active_d;
`endif
    end
  end

`ifdef PC_NEST_EN
  // Return stack storage; validity is tracked by sp_q alone, so no reset needed.
  always_ff @(negedge clk) begin
    if (reset && take) begin
      stk_pc_q[push_idx] <= next_pc;
      stk_id_q[push_idx] <= int_id_q;
    end
  end

  assign int_active = (sp_q != '0);
`else
  assign int_active = int_active_q;
`endif

  assign pc_out  = pc_q;
  assign int_id  = int_id_q;
  assign pending = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_irq_vec.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_irq_vec
// Purpose  : Scoreboard bench for pc_irq_vec. Each step pushes the expected
//            PC / int_id / int_active; a monitor pops and compares once the
//            DUT has acted on the strobe edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_irq_vec;

  localparam logic [26:0] PC_START = 27'hC02422;

  typedef struct {
    logic [26:0] pc;
    logic [7:0]  id;
    logic        act;
  } exp_t;

  logic        clk, reset, step, jump, offset, reti, mask_wr;
  logic [26:0] jump_addr;
  logic [7:0]  int_req, mask_data;
  logic [26:0] pc_out;
  logic [7:0]  int_id;
  logic        int_active;
  logic [7:0]  pending;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic stp_prev = 1'b0;

  pc_irq_vec dut (
    .clk(clk), .reset(reset), .step(step), .jump(jump), .offset(offset),
    .jump_addr(jump_addr), .reti(reti), .int_req(int_req), .mask_wr(mask_wr),
    .mask_data(mask_data), .pc_out(pc_out), .int_id(int_id),
    .int_active(int_active), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // id visible after a return: nesting restores the outer id, flat mode keeps the handler's
  function automatic logic [7:0] idr(input logic [7:0] handler, input logic [7:0] prior);
`ifdef PC_NEST_EN
    return prior;
`else
    return handler;
`endif
  endfunction

  // Scoreboard consumer: after each strobe edge the DUT must show the next expected state.
  always @(negedge clk) begin
    if (!reset) begin
      stp_prev = 1'b0;
    end else if (step && !stp_prev) begin
      stp_prev = step;
      #1;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: step edge with no expectation, pc_out=%h", pc_out);
      end else begin
        mon_e = sb.pop_front();
        if (pc_out !== mon_e.pc || int_id !== mon_e.id || int_active !== mon_e.act) begin
          errors++;
          $display("FAIL step_result: got pc=%h id=%0d act=%b, want pc=%h id=%0d act=%b",
                   pc_out, int_id, int_active, mon_e.pc, mon_e.id, mon_e.act);
        end
      end
    end else begin
      stp_prev = step;
    end
  end

  // One write-back strobe with the given instruction fields and its expected outcome.
  task automatic do_step(input logic j, input logic o, input logic [26:0] a, input logic r,
                         input logic [26:0] epc, input logic [7:0] eid, input logic eact);
    exp_t e;
    e.pc = epc; e.id = eid; e.act = eact;
    sb.push_back(e);
    @(posedge clk);
    jump = j; offset = o; jump_addr = a; reti = r; step = 1'b1;
    @(posedge clk);
    step = 1'b0; jump = 1'b0; offset = 1'b0; jump_addr = '0; reti = 1'b0;
    @(posedge clk);
  endtask

  task automatic fire(input logic [7:0] m);
    @(posedge clk); int_req = m;
    @(posedge clk); int_req = '0;
  endtask

  task automatic write_mask(input logic [7:0] m);
    @(posedge clk); mask_wr = 1'b1; mask_data = m;
    @(posedge clk); mask_wr = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    checks++;
    if (pc_out !== PC_START || int_id !== 8'd0 || int_active !== 1'b0 || pending !== 8'h00) begin
      errors++;
      $display("FAIL reset_values: got pc=%h id=%0d act=%b pend=%h, want pc=%h id=0 act=0 pend=00",
               pc_out, int_id, int_active, pending, PC_START);
    end
    reset = 1'b1;
    do_step(0, 0, 0, 0, 27'hC02423, 0, 0);
    do_step(0, 0, 0, 0, 27'hC02424, 0, 0);
    do_step(0, 0, 0, 0, 27'hC02425, 0, 0);
  endtask

  // Strobe held high for several cycles must advance only once.
  task automatic test_step_hold;
    exp_t e;
    e.pc = 27'hC02426; e.id = 0; e.act = 0;
    sb.push_back(e);
    @(posedge clk); step = 1'b1;
    repeat (3) @(posedge clk);
    checks++;
    if (pc_out !== 27'hC02426) begin
      errors++;
      $display("FAIL step_hold: got pc=%h want pc=%h", pc_out, 27'hC02426);
    end
    step = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_jump;
    do_step(1, 0, 27'd10, 0, 27'd10, 0, 0);
    do_step(1, 1, 27'h7FFFFFF, 0, 27'd9, 0, 0);
    do_step(1, 0, 27'd100, 0, 27'd100, 0, 0);
  endtask

  task automatic test_priority;
    do_step(1, 0, 27'd50, 0, 27'd50, 0, 0);
    fire(8'h24);
    checks++;
    if (pending !== 8'h24) begin
      errors++; $display("FAIL prio_pending_set: got %h want 24", pending);
    end
    do_step(0, 0, 0, 0, 27'd3, 8'd2, 1);
    checks++;
    if (pending !== 8'h20) begin
      errors++; $display("FAIL prio_pending_clr: got %h want 20", pending);
    end
    do_step(0, 0, 0, 1, 27'd51, idr(2, 0), 0);
    do_step(0, 0, 0, 0, 27'd6, 8'd5, 1);
    checks++;
    if (pending !== 8'h00) begin
      errors++; $display("FAIL prio_pending_empty: got %h want 00", pending);
    end
    do_step(0, 0, 0, 1, 27'd52, idr(5, 0), 0);
  endtask

  task automatic test_mask;
    write_mask(8'hFE);
    fire(8'h01);
    do_step(0, 0, 0, 0, 27'd53, idr(5, 0), 0);
    checks++;
    if (pending !== 8'h01) begin
      errors++; $display("FAIL mask_hold_pending: got %h want 01", pending);
    end
    write_mask(8'hFF);
    do_step(0, 0, 0, 0, 27'd1, 8'd0, 1);
    checks++;
    if (pending !== 8'h00) begin
      errors++; $display("FAIL mask_taken_clear: got %h want 00", pending);
    end
    do_step(0, 0, 0, 1, 27'd54, 8'd0, 0);
  endtask

  task automatic test_rom_guard;
    do_step(1, 0, PC_START, 0, PC_START, 0, 0);
    fire(8'h08);
    do_step(0, 0, 0, 0, 27'hC02423, 0, 0);
    checks++;
    if (pending !== 8'h08) begin
      errors++; $display("FAIL rom_pending_kept: got %h want 08", pending);
    end
    do_step(1, 0, 27'hC02421, 0, 27'hC02421, 0, 0);
    do_step(0, 0, 0, 0, 27'd4, 8'd3, 1);
    do_step(0, 0, 0, 1, PC_START, idr(3, 0), 0);
  endtask

  task automatic test_jump_entry_reset;
    do_step(1, 0, 27'd30, 0, 27'd30, idr(3, 0), 0);
    fire(8'h40);
    do_step(1, 0, 27'd200, 0, 27'd7, 8'd6, 1);
    do_step(0, 0, 0, 1, 27'd200, idr(6, 0), 0);
    fire(8'h02);
    do_step(0, 0, 0, 0, 27'd2, 8'd1, 1);
    @(posedge clk); reset = 1'b0;
    repeat (2) @(posedge clk);
    checks++;
    if (pc_out !== PC_START || int_active !== 1'b0 || int_id !== 8'd0 || pending !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_handler: got pc=%h act=%b id=%0d pend=%h, want pc=%h act=0 id=0 pend=00",
               pc_out, int_active, int_id, pending, PC_START);
    end
    reset = 1'b1;
    @(posedge clk);
  endtask

`ifdef PC_NEST_EN
  task automatic test_nesting;
    do_step(1, 0, 27'd40, 0, 27'd40, 0, 0);
    fire(8'h10);
    do_step(0, 0, 0, 0, 27'd5, 8'd4, 1);
    fire(8'h02);
    do_step(0, 0, 0, 0, 27'd2, 8'd1, 1);
    fire(8'h40);
    do_step(0, 0, 0, 0, 27'd3, 8'd1, 1);
    do_step(0, 0, 0, 1, 27'd6, 8'd4, 1);
    do_step(0, 0, 0, 0, 27'd7, 8'd4, 1);
    do_step(0, 0, 0, 1, 27'd41, 8'd0, 0);
    do_step(0, 0, 0, 0, 27'd7, 8'd6, 1);
    fire(8'h20);
    do_step(0, 0, 0, 0, 27'd6, 8'd5, 1);
    fire(8'h08);
    do_step(0, 0, 0, 0, 27'd4, 8'd3, 1);
    fire(8'h04);
    do_step(0, 0, 0, 0, 27'd3, 8'd2, 1);
    fire(8'h01);
    do_step(0, 0, 0, 0, 27'd4, 8'd2, 1);
    checks++;
    if (pending !== 8'h01) begin
      errors++; $display("FAIL nest_full_pending: got %h want 01", pending);
    end
    do_step(0, 0, 0, 1, 27'd5, 8'd3, 1);
    do_step(0, 0, 0, 1, 27'd7, 8'd5, 1);
    do_step(0, 0, 0, 1, 27'd8, 8'd6, 1);
    do_step(0, 0, 0, 1, 27'd42, 8'd0, 0);
    do_step(0, 0, 0, 0, 27'd1, 8'd0, 1);
    do_step(0, 0, 0, 1, 27'd43, 8'd0, 0);
  endtask
`endif

  initial begin
    reset = 1'b0; step = 1'b0; jump = 1'b0; offset = 1'b0; reti = 1'b0;
    jump_addr = '0; int_req = '0; mask_wr = 1'b0; mask_data = '0;
    test_reset();
    test_step_hold();
    test_jump();
    test_priority();
    test_mask();
    test_rom_guard();
    test_jump_entry_reset();
`ifdef PC_NEST_EN
    test_nesting();
`endif
    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/pc_irq_vec.md
# pc_irq_vec

Parametrised program counter with a vectored, maskable, prioritised interrupt unit for the FPGC CPU. Sits in the CPU next to the control unit. Advances, jumps or redirects the PC once per instruction write-back. Latches rising edges on `NUM_INT` interrupt lines. Vectors to a per-channel address and restores the interrupted PC on `reti`.

## Interface
- `ADDR_W`, 27: PC / address width.
- `NUM_INT`, 8: number of interrupt channels (1..32).
- `PC_START`, 27'hC02422: reset PC (internal ROM base); interrupts are never taken while `pc_out >= PC_START`.
- `VEC_BASE`, 1: vector of channel 0; channel i vectors to `VEC_BASE + i`.
- `NEST_DEPTH`, 4: backup stack depth; used only with `PC_NEST_EN`.

Ports:
- `clk`  input  1  CPU clock; all state updates on falling edge.
- `reset`  input  1  synchronous, active-low reset.
- `step`  input  1  write-back strobe; the PC acts on its rising edge only.
- `jump`  input  1  current instruction jumps.
- `offset`  input  1  jump is PC-relative.
- `jump_addr`  input  `ADDR_W`  jump target or offset.
- `reti`  input  1  current instruction is return-from-interrupt.
- `int_req`  input  `NUM_INT`  interrupt lines, rising-edge sensitive.
- `mask_wr`  input  1  load `mask_data` into the mask register.
- `mask_data`  input  `NUM_INT`  1 = channel enabled.
- `pc_out`  output  `ADDR_W`  program counter.
- `int_id`  output  8  index of the last channel taken.
- `int_active`  output  1  handler in progress.
- `pending`  output  `NUM_INT`  latched, not-yet-serviced requests.

## Operation
- `step_edge = step & ~step_prev`.
- `req_edge[i] = int_req[i] & ~int_req_prev[i]`. Both `_prev` registers update every cycle, outside reset.
- A `req_edge[i]` sets `pending[i]`. Taking channel i clears it. If a new edge and a take of the same channel occur together, the set wins.
- `eligible = pending & mask`. The selected channel `sel` is the lowest set index; channel 0 has the highest priority.
- Take condition: `step_edge & ~reti & int_en & |eligible & (pc_out < PC_START)`.
- On a `step_edge`, the first matching case wins:
  1. `reti & int_active`: `pc_out <= backup`, `int_en <= 1`, `int_active <= 0`.
  2. Take condition:
     - `backup <= next_pc`.
     - `pc_out <= VEC_BASE + sel`.
     - `int_id <= sel`, `int_active <= 1`, `int_en <= 0`, `pending[sel] <= 0`.
  3. Otherwise: `pc_out <= next_pc`.
- `next_pc` is:
  - `pc_out + jump_addr` when `jump & offset`;
  - `jump_addr` when `jump & ~offset`;
  - `pc_out + 1` otherwise.
  - All sums wrap modulo 2^`ADDR_W`.
- `reti` while `int_active = 0` is treated as a normal instruction (case 3).
- `mask_wr` loads the mask in that cycle. Masked channels stay pending and become eligible when unmasked.
- Interrupts are neither taken nor lost while the PC is in ROM; pending bits persist.

## Timing
- `pc_out` changes on the first falling edge at which `step_edge` is seen, i.e. one half-cycle after `step` rises. It then holds until the next edge.
- `int_req` rising → `pending` set: 1 cycle.
- `pending` → vector: the next `step_edge` with the take condition true.
- A mask write affects selection from the following cycle.
- Reset values (when `reset` is low, reset overrides everything):
  - `pc_out = PC_START`, `int_id = 0`, `int_active = 0`, `pending = 0`;
  - mask all ones, `int_en = 1`, backup 0;
  - all `_prev` registers 0.
- Reset mid-handler discards the backup and any nesting state.

## Configuration
- `PC_NEST_EN` defined:
  - backup becomes a LIFO of `NEST_DEPTH` entries; `int_active = stack non-empty`.
  - On entry, push `next_pc` and the current `int_id`.
  - `int_en` stays 1. A new take requires `sel < int_id` of the active channel and a stack that is not full.
  - `reti` pops `pc_out` and `int_id`.
  - When the stack is full, requests remain pending.
- `PC_NEST_EN` undefined: single backup register; nesting is impossible (`int_en` cleared on entry).

## Test plan
- **Reset and stepping:** release reset, pulse `step` 3×, no jump → `pc_out` reads 27'hC02422, then C02423, C02424, C02425; outputs at reset values.
- **Relative jump:** `pc_out = 10`, `jump=1`, `offset=1`, `jump_addr = 27'h7FFFFFF` → `pc_out = 9` (wrap). Absolute jump to 100 → 100.
- **Priority:** `pc_out = 50`; edges on channels 5 and 2 in the same cycle; step → `pc_out = 3`, `int_id = 2`, `pending = 8'h20`, backup 51. `reti` step → `pc_out = 51`. Next step → `pc_out = 6`, `int_id = 5`.
- **Mask and ROM guard:**
  - Mask `8'hFE` with a channel 0 edge → no vector; `pending[0]` stays set.
  - Unmask → vector to 1 on the next step.
  - With `pc_out >= PC_START`, an edge on channel 3 is not taken until the PC drops below.
- **Jump on entry and reset mid-handler:**
  - Interrupt taken while `jump=1`, `offset=0`, `jump_addr = 200` → backup 200; `reti` → 200.
  - Assert reset inside a handler → `pc_out = PC_START`, `int_active = 0`.
- **`PC_NEST_EN` nesting:**
  - In a handler for channel 4, a channel 1 edge preempts; two `reti` return in order.
  - Channel 6 during channel 4 waits.
  - With `NEST_DEPTH` full, further requests stay pending.
